vga_frame_capture: RTL and testbench
====================================

# vga_frame_capture

Receive-side monitor for the miner's 640x480 VGA output: samples the same `vga_h_sync`/`vga_v_sync`/`vga_R`/`vga_G`/`vga_B` signals the display path drives. It locks to the sync pattern, checks line and frame lengths against the timing constants, and reports per-frame results: lit-pixel count, RGB signature and frame counter. It sits beside the top level in simulation and optionally on-chip as a self-check of the display path.

## Interface
- `H_SYNC`, 96: hsync pulse width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `H_ACTIVE`, 640: visible pixels per line
- `H_TOTAL`, 800: pixels per line
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BP`, 33: vertical back porch, lines
- `V_ACTIVE`, 480: visible lines
- `V_TOTAL`, 525: lines per frame

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `pix_en` in 1: pixel strobe; inputs are sampled only when high
- `vga_h_sync`, `vga_v_sync` in 1: syncs, active-low
- `vga_R`, `vga_G`, `vga_B` in 1: pixel colour
- `err_clr` in 1: clears `timing_err`
- `locked` out 1: timing verified
- `frame_done` out 1: one-`clk` pulse, frame results valid
- `frame_count` out 16: frames completed while locked, wraps
- `lit_count` out 19: active pixels with any of R/G/B high, last frame
- `signature` out 16: CRC of the last frame's active pixels
- `timing_err` out 1: sticky error flag

## Operation
- All sampling and edge detection happen on `pix_en` cycles. `hs_q`/`vs_q` hold the previous sample.
- **Falling-edge definitions:** hsync falling edge (HF) = sample 0 with `hs_q`=1; vsync falling edge (VF) likewise on `vs_q`.
- **h_cnt (11 bits):**
  - On HF, cleared to 0; that pixel is h_cnt=0.
  - Otherwise increments, saturating at 2047.
- **v_cnt (10 bits):**
  - On HF, increments, saturating at 1023.
  - On VF, cleared to 0, overriding the HF increment when both occur on the same sample.
- **Active pixel:** `H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE` and `V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE`.
- **Per active pixel:**
  - `lit_acc` increments if R|G|B.
  - With the signature enabled, the CRC shifts in {R,G,B}, MSB first.
- **Accumulators:** `lit_acc` clears to 0 and the CRC to 0xFFFF on every VF, after being transferred to the outputs when required.
- **Line check:** at HF, h_cnt+1 must equal H_TOTAL. Skipped on the first HF after SEARCH.
- **Frame check:** at VF, v_cnt+1 must equal V_TOTAL.
- **States:**
  - SEARCH: at the first VF, go to SYNC.
  - SYNC:
    - At VF with all line and frame checks of the frame passed: go to LOCKED, emit results.
    - Any failed check: stay in SYNC. The next VF restarts verification.
  - LOCKED:
    - At VF with checks passed: emit results.
    - Any failed line or frame check: go to SEARCH, set `timing_err`, drop `locked` the next `clk`.
- **Emit results:**
  - `lit_count` and `signature` load from the accumulators.
  - `frame_count` increments.
  - `frame_done` pulses.
- **`timing_err`:**
  - Set only from LOCKED.
  - `err_clr` clears it.
  - When set and clear occur on the same cycle, set wins.
- **Reset (mid-frame or otherwise):**
  - State returns to SEARCH; all counters and accumulators return to 0, CRC to 0xFFFF.
  - No `frame_done` for a partial frame.

## Timing
- Reset values: `locked`=0, `frame_done`=0, `frame_count`=0, `lit_count`=0, `signature`=0, `timing_err`=0.
- `frame_done` asserts on the `clk` after the `pix_en` cycle that sampled VF, for exactly one `clk`. Outputs are stable from that cycle until the next emit.
- `locked` rises together with the first `frame_done`, i.e. at the end of the second full frame after reset.
- `locked` falls one `clk` after the failing HF/VF sample.
- `pix_en` low holds all state. Gaps in `pix_en` are allowed.

## Configuration
- `VGA_CAP_SIG_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no final XOR) computed over active pixels.
  - `signature` is loaded at each emit.
- `VGA_CAP_SIG_EN` undefined:
  - No CRC logic.
  - `signature` is constant 0; all other behaviour is identical.

## Structure
- **Package `bitminer_vga_pkg`:**
  - 640x480@60 timing constants, reused as parameter defaults here and by the display generator.
  - State enum {SEARCH, SYNC, LOCKED}.
  - CRC polynomial and init constants.
- **Sub-module `vga_sig_crc16`:** combinational 3-bit-per-step CRC-16 update (`crc_in`, `data[2:0]`, `crc_out`). Instantiated only under `VGA_CAP_SIG_EN`.

## Test plan
- Ideal timing, all-black frames, `pix_en` every other `clk` -> `locked`=1 and first `frame_done` after frame 2; `lit_count`=0; `frame_count` 1,2,3.
- Full white active area -> `lit_count`=307200. A single lit pixel at h_cnt=144, v_cnt=35 -> `lit_count`=1. Signature matches the bench's reference CRC (`VGA_CAP_SIG_EN` defined), else 0.
- While locked, one line of 799 pixels -> `timing_err`=1, `locked`=0 next `clk`, no `frame_done` for that frame. Relock after two clean frames. `err_clr` -> `timing_err`=0.
- Frame of 524 lines in SYNC -> stays unlocked, `timing_err`=0, locks after next clean frame.
- `rst_n` pulsed low mid-frame while locked -> all outputs 0 immediately, no spurious `frame_done`, relock after two frames.
- VF and HF on the same sample -> v_cnt=0, h_cnt=0; `err_clr` and error on the same cycle -> `timing_err`=1.

Source files
------------

// File: rtl/bitminer_vga_pkg.sv
// Shared 640x480@60 VGA timing constants, frame-capture state encoding and
// CRC-16-CCITT constants. The display generator and vga_frame_capture both use
// these values.
package bitminer_vga_pkg;

  // Horizontal timing, in pixels
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_TOTAL  = 800;

  // Vertical timing, in lines
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_TOTAL  = 525;

  // Counter and result widths
  localparam int unsigned H_CNT_W  = 11;
  localparam int unsigned V_CNT_W  = 10;
  localparam int unsigned LIT_W    = 19;
  localparam int unsigned FCNT_W   = 16;
  localparam int unsigned SIG_W    = 16;

  // CRC-16-CCITT, no final XOR
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

endpackage

// File: rtl/vga_sig_crc16.sv
// Combinational CRC-16-CCITT update, three data bits per step, MSB first.
// Ports:
//   crc_in  [15:0] : current CRC
//   data    [2:0]  : {R,G,B}, data[2] shifted in first
//   crc_out [15:0] : CRC after the three bits
module vga_sig_crc16
  import bitminer_vga_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [2:0]  data,
  output logic [15:0] crc_out
);

  // Bit-serial update unrolled over the three colour bits
  always_comb begin
    crc_out = crc_in;
    for (int i = 2; i >= 0; i--) begin
      crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ data[i]) ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/vga_frame_capture.sv
// Receive-side VGA monitor: locks to the sync pattern, checks line and frame
// lengths and reports per-frame lit-pixel count, RGB signature and frame count.
// Optional feature macro: VGA_CAP_SIG_EN (CRC-16 signature; otherwise 0).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   pix_en           : pixel strobe, inputs sampled only when high
//   vga_h_sync/v_sync: active-low syncs
//   vga_R/G/B        : pixel colour
//   err_clr          : clears timing_err
//   locked           : timing verified
//   frame_done       : one-clk pulse, frame results valid
//   frame_count      : frames completed while locked
//   lit_count        : lit active pixels of the last frame
//   signature        : CRC of the last frame's active pixels
//   timing_err       : sticky timing error seen while locked
module vga_frame_capture
  import bitminer_vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic        vga_R,
  input  logic        vga_G,
  input  logic        vga_B,
  input  logic        err_clr,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [18:0] lit_count,
  output logic [15:0] signature,
  output logic        timing_err
);

  localparam logic [H_CNT_W-1:0] H_ACT_LO = H_CNT_W'(H_SYNC + H_BP);
  localparam logic [H_CNT_W-1:0] H_ACT_HI = H_CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_LO = V_CNT_W'(V_SYNC + V_BP);
  localparam logic [V_CNT_W-1:0] V_ACT_HI = V_CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);

  cap_state_e         state, state_nxt;
  logic               sync_bad, sync_bad_nxt;
  logic               hs_q, vs_q;
  logic               skip_line;
  logic [H_CNT_W-1:0] h_cnt, h_nxt_c;
  logic [V_CNT_W-1:0] v_cnt, v_nxt_c;
  logic [LIT_W-1:0]   lit_acc;
  logic               hf_c, vf_c, active_c;
  logic               line_bad_c, frame_bad_c;
  logic               emit_c, err_set_c;

  // Edge detection and counter next values; the current sample is classified
  // with the updated counters so the HF pixel itself is h_cnt=0.
  always_comb begin
    hf_c    = pix_en & ~vga_h_sync & hs_q;
    vf_c    = pix_en & ~vga_v_sync & vs_q;
    h_nxt_c = h_cnt;
    v_nxt_c = v_cnt;
    if (hf_c) begin
      h_nxt_c = '0;
    end else if (h_cnt != '1) begin
      h_nxt_c = h_cnt + H_CNT_W'(1);
    end
    if (vf_c) begin
      v_nxt_c = '0;
    end else if (hf_c && (v_cnt != '1)) begin
      v_nxt_c = v_cnt + V_CNT_W'(1);
    end
    active_c    = pix_en && (h_nxt_c >= H_ACT_LO) && (h_nxt_c < H_ACT_HI) &&
                  (v_nxt_c >= V_ACT_LO) && (v_nxt_c < V_ACT_HI);
    line_bad_c  = hf_c && !skip_line && (h_cnt != H_LAST);
    frame_bad_c = vf_c && (v_cnt != V_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      sync_bad <= 1'b0;
    end else begin
      state    <= state_nxt;
      sync_bad <= sync_bad_nxt;
    end
  end

  // Next-state logic; sync_bad collects line failures seen while in SYNC
  always_comb begin
    state_nxt    = state;
    sync_bad_nxt = sync_bad;
    emit_c       = 1'b0;
    err_set_c    = 1'b0;
    case (state)
      SEARCH: begin
        if (vf_c) begin
          state_nxt    = SYNC;
          sync_bad_nxt = 1'b0;
        end
      end
      SYNC: begin
        if (vf_c) begin
          sync_bad_nxt = 1'b0;
          if (!sync_bad && !line_bad_c && !frame_bad_c) begin
            state_nxt = LOCKED;
            emit_c    = 1'b1;
          end
        end else if (line_bad_c) begin
          sync_bad_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (line_bad_c || frame_bad_c) begin
          state_nxt = SEARCH;
          err_set_c = 1'b1;
        end else if (vf_c) begin
          emit_c = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Sampling, counters, accumulators and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      skip_line   <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      lit_acc     <= '0;
      locked      <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      lit_count   <= '0;
      timing_err  <= 1'b0;
    end else begin
      if (pix_en) begin
        hs_q  <= vga_h_sync;
        vs_q  <= vga_v_sync;
        h_cnt <= h_nxt_c;
        v_cnt <= v_nxt_c;
        if (state == SEARCH) begin
          skip_line <= 1'b1;
        end else if (hf_c) begin
          skip_line <= 1'b0;
        end
        if (vf_c) begin
          lit_acc <= '0;
        end else if (active_c && (vga_R | vga_G | vga_B)) begin
          lit_acc <= lit_acc + LIT_W'(1);
        end
      end
      frame_done <= emit_c;
      if (emit_c) begin
        lit_count   <= lit_acc;
        frame_count <= frame_count + FCNT_W'(1);
      end
      locked <= (state_nxt == LOCKED);
      // set has priority over clear
      if (err_set_c) begin
        timing_err <= 1'b1;
      end else if (err_clr) begin
        timing_err <= 1'b0;
      end
    end
  end

`ifdef VGA_CAP_SIG_EN
  logic [SIG_W-1:0] crc, crc_upd_c;

  vga_sig_crc16 u_crc (
    .crc_in  (crc),
    .data    ({vga_R, vga_G, vga_B}),
    .crc_out (crc_upd_c)
  );

  // Running CRC over active pixels, captured into signature on emit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc       <= CRC16_INIT;
      signature <= '0;
    end else begin
      if (pix_en) begin
        if (vf_c) begin
          crc <= CRC16_INIT;
        end else if (active_c) begin
          crc <= crc_upd_c;
        end
      end
      if (emit_c) begin
        signature <= crc;
      end
    end
  end
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture using a reduced 20x14 timing so that
// whole frames run in a few hundred pixels.
module tb_vga_frame_capture;

  localparam int HS = 4, HBP = 3, HA = 8, HT = 20;
  localparam int VS = 2, VBP = 3, VA = 6, VT = 14;
  localparam int HLO = HS + HBP, HHI = HS + HBP + HA;
  localparam int VLO = VS + VBP, VHI = VS + VBP + VA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic        vga_h_sync, vga_v_sync;
  logic        vga_R, vga_G, vga_B;
  logic        err_clr;
  logic        locked, frame_done, timing_err;
  logic [15:0] frame_count;
  logic [18:0] lit_count;
  logic [15:0] signature;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  bit gap = 1'b1;

  vga_frame_capture #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .vga_h_sync  (vga_h_sync),
    .vga_v_sync  (vga_v_sync),
    .vga_R       (vga_R),
    .vga_G       (vga_G),
    .vga_B       (vga_B),
    .err_clr     (err_clr),
    .locked      (locked),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .lit_count   (lit_count),
    .signature   (signature),
    .timing_err  (timing_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [2:0] pix_rgb(input int mode, input int l, input int p);
    logic act;
    act = (p >= HLO) && (p < HHI) && (l >= VLO) && (l < VHI);
    case (mode)
      1: return act ? 3'b111 : 3'b000;
      2: return (p == HLO && l == VLO) ? 3'b100 : 3'b000;
      3: begin
        if ((p == HLO && l == VLO) || (p == HHI-1 && l == VHI-1)) return 3'b010;
        if ((p == HLO-1 && l == VLO) || (p == HHI && l == VLO) ||
            (p == HLO && l == VLO-1) || (p == HLO && l == VHI)) return 3'b001;
        return 3'b000;
      end
      default: return 3'b000;
    endcase
  endfunction

  // Reference signature: plain bitwise CRC-16-CCITT over active pixels
  function automatic logic [15:0] ref_sig(input int mode);
`ifdef VGA_CAP_SIG_EN
    logic [15:0] c;
    logic [2:0]  px;
    c = 16'hFFFF;
    for (int l = VLO; l < VHI; l++) begin
      for (int p = HLO; p < HHI; p++) begin
        px = pix_rgb(mode, l, p);
        for (int b = 2; b >= 0; b--) begin
          c = c ^ {px[b], 15'b0};
          c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
      end
    end
    return c;
`else
    if (mode < 0) return 16'hFFFF;
    return 16'h0000;
`endif
  endfunction

  task automatic send_pix(input logic hs, input logic vs, input logic [2:0] rgb);
    vga_h_sync = hs;
    vga_v_sync = vs;
    {vga_R, vga_G, vga_B} = rgb;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_line(input int l, input int first, input int len, input int mode);
    for (int p = first; p < len; p++)
      send_pix(logic'(p >= HS), logic'(l >= VS), pix_rgb(mode, l, p));
  endtask

  task automatic send_frame(input int nlines, input int short_line, input int mode);
    for (int l = 0; l < nlines; l++)
      send_line(l, 0, (l == short_line) ? HT - 1 : HT, mode);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_done"},   32'(frame_done), 0);
    check({tag, "_fcnt"},   32'(frame_count), 0);
    check({tag, "_lit"},    32'(lit_count), 0);
    check({tag, "_sig"},    32'(signature), 0);
    check({tag, "_err"},    32'(timing_err), 0);
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; err_clr = 1'b0;
    vga_h_sync = 1'b1; vga_v_sync = 1'b1;
    {vga_R, vga_G, vga_B} = 3'b000;
    idle(3);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // pix_en every other clk: lock after two frames
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    check("f2_locked", 32'(locked), 0);
    check("f2_done", 32'(done_cnt), 0);
    send_frame(VT, -1, 1);
    check("f3_locked", 32'(locked), 1);
    check("f3_fcnt", 32'(frame_count), 1);
    check("f3_lit", 32'(lit_count), 0);
    check("f3_done", 32'(done_cnt), 1);
    check("f3_sig", 32'(signature), 32'(ref_sig(0)));
    send_frame(VT, -1, 2);
    check("white_fcnt", 32'(frame_count), 2);
    check("white_lit", 32'(lit_count), HA * VA);
    check("white_sig", 32'(signature), 32'(ref_sig(1)));
    send_frame(VT, -1, 3);
    check("single_fcnt", 32'(frame_count), 3);
    check("single_lit", 32'(lit_count), 1);
    check("single_sig", 32'(signature), 32'(ref_sig(2)));

    // Short line while locked
    gap = 1'b0;
    for (int l = 0; l < 4; l++) send_line(l, 0, (l == 3) ? HT - 1 : HT, 0);
    check("edge_fcnt", 32'(frame_count), 4);
    check("edge_lit", 32'(lit_count), 2);
    check("edge_sig", 32'(signature), 32'(ref_sig(3)));
    check("pre_err_locked", 32'(locked), 1);
    send_line(4, 0, 1, 0);
    check("short_locked", 32'(locked), 0);
    check("short_err", 32'(timing_err), 1);
    send_line(4, 1, HT, 0);
    for (int l = 5; l < VT; l++) send_line(l, 0, HT, 0);
    send_frame(VT, -1, 0);
    check("relock1_locked", 32'(locked), 0);
    check("relock1_done", 32'(done_cnt), 4);
    send_frame(VT, -1, 0);
    check("relock2_locked", 32'(locked), 1);
    check("relock2_done", 32'(done_cnt), 5);
    check("relock2_fcnt", 32'(frame_count), 5);
    check("relock2_err", 32'(timing_err), 1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("clr_err", 32'(timing_err), 0);

    // Error and err_clr on the same cycle: set wins
    for (int l = 0; l < 4; l++) send_line(l, 0, (l == 3) ? HT - 1 : HT, 0);
    err_clr = 1'b1;
    send_line(4, 0, 1, 0);
    err_clr = 1'b0;
    check("setclr_err", 32'(timing_err), 1);
    check("setclr_locked", 32'(locked), 0);
    send_line(4, 1, HT, 0);
    for (int l = 5; l < VT; l++) send_line(l, 0, HT, 0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("clr2_err", 32'(timing_err), 0);

    // Short frame while in SYNC
    send_frame(VT - 1, -1, 0);
    send_frame(VT, -1, 0);
    check("sync_short_locked", 32'(locked), 0);
    check("sync_short_err", 32'(timing_err), 0);
    check("sync_short_done", 32'(done_cnt), 6);
    send_frame(VT, -1, 0);
    check("sync_relock", 32'(locked), 1);
    check("sync_relock_done", 32'(done_cnt), 7);
    check("sync_relock_fcnt", 32'(frame_count), 7);

    // Reset mid-frame while locked
    for (int l = 0; l < 7; l++) send_line(l, 0, HT, 0);
    check("pre_rst_fcnt", 32'(frame_count), 8);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    idle(2);
    rst_n = 1'b1;
    for (int l = 7; l < VT; l++) send_line(l, 0, HT, 0);
    send_frame(VT, -1, 1);
    check("rst_f1_locked", 32'(locked), 0);
    check("rst_f1_done", 32'(done_cnt), 8);
    send_frame(VT, -1, 0);
    check("rst_relock", 32'(locked), 1);
    check("rst_relock_fcnt", 32'(frame_count), 1);
    check("rst_relock_lit", 32'(lit_count), HA * VA);
    check("rst_relock_done", 32'(done_cnt), 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
